// File: rtl/contador_duzias_datapath_if.sv
// Handshake between the dozen-counting FSM and its datapath, plus the
// display/status outputs the datapath exposes.
interface contador_duzias_datapath_if;
    logic       clear;
    logic       cont1;
    logic       add_cont12;
    logic       cont12;
    logic [3:0] units;
    logic [6:0] dozens;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       dozen_pulse;
    logic       full;
    logic       overflow;

    // FSM/controller side
    modport master (
        output clear, cont1, add_cont12,
        input  cont12, units, dozens, bcd_tens, bcd_ones, dozen_pulse, full, overflow
    );

    // Datapath side
    modport slave (
        input  clear, cont1, add_cont12,
        output cont12, units, dozens, bcd_tens, bcd_ones, dozen_pulse, full, overflow
    );
endinterface

// File: rtl/contador_duzias_datapath.sv
// Bottle/dozen counting datapath for the bottling-line FSM: counts bottles in
// the current dozen, books completed dozens (saturating) and drives BCD digits.
module contador_duzias_datapath #(
    parameter int DOZEN_SIZE = 12,
    parameter int MAX_DOZENS = 99
) (
    input  logic                          clk,
    input  logic                          reset,
    contador_duzias_datapath_if.slave     bus
);
    logic [3:0] units_q;
    logic [6:0] dozens_q;
    logic [3:0] tens_q, ones_q;
    logic [3:0] tens_d, ones_d;
    logic       add_prev, pulse_q, ovf_q;
    logic       at_dozen, dozen_evt;

    assign at_dozen  = (units_q == 4'(DOZEN_SIZE));
    // Edge-detect add_cont12 so a long FSM dozen state books only one dozen
    assign dozen_evt = bus.add_cont12 & ~add_prev & at_dozen;

    // Binary to BCD by constant compares; the largest threshold passed wins
    always_comb begin
        tens_d = '0;
        ones_d = dozens_q[3:0];
        for (int i = 1; i <= 9; i++) begin
            if (dozens_q >= 7'(10 * i)) begin
                tens_d = 4'(i);
                ones_d = 4'(dozens_q - 7'(10 * i));
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            units_q  <= '0;
            dozens_q <= '0;
            tens_q   <= '0;
            ones_q   <= '0;
            add_prev <= 1'b0;
            pulse_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (bus.clear) begin
            units_q  <= '0;
            dozens_q <= '0;
            tens_q   <= '0;
            ones_q   <= '0;
            add_prev <= 1'b0;
            pulse_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            add_prev <= bus.add_cont12;
            pulse_q  <= dozen_evt;
            tens_q   <= tens_d;
            ones_q   <= ones_d;
            if (dozen_evt) begin
                // A bottle arriving on the booking cycle starts the next dozen
                units_q <= bus.cont1 ? 4'd1 : 4'd0;
                if (dozens_q < 7'(MAX_DOZENS)) dozens_q <= dozens_q + 7'd1;
                else                           ovf_q    <= 1'b1;
            end else if (bus.cont1) begin
                if (at_dozen) ovf_q   <= 1'b1;
                else          units_q <= units_q + 4'd1;
            end
        end
    end

    assign bus.cont12      = at_dozen;
    assign bus.units       = units_q;
    assign bus.dozens      = dozens_q;
    assign bus.bcd_tens    = tens_q;
    assign bus.bcd_ones    = ones_q;
    assign bus.dozen_pulse = pulse_q;
    assign bus.full        = (dozens_q == 7'(MAX_DOZENS));
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_contador_duzias_datapath.sv
// Scoreboard bench: the driver pushes model predictions per cycle, a monitor
// pops and compares them just after each rising edge.
module tb_contador_duzias_datapath;
    localparam int DS  = 12;
    localparam int MAX = 99;

    typedef struct {
        int units, dozens, tens, ones, pulse, full, ovf, cont12;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    contador_duzias_datapath_if bus();

    contador_duzias_datapath #(.DOZEN_SIZE(DS), .MAX_DOZENS(MAX)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int total = 0, bad = 0;

    // Reference state: plain integers
    int m_units = 0, m_dozens = 0, m_ovf = 0, m_prev = 0, m_pulse = 0;
    int m_tens = 0, m_ones = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.units = m_units;  e.dozens = m_dozens;
        e.tens  = m_tens;   e.ones   = m_ones;
        e.pulse = m_pulse;  e.ovf    = m_ovf;
        e.full  = (m_dozens == MAX);
        e.cont12 = (m_units == DS);
        return e;
    endfunction

    task automatic model_zero();
        m_units = 0; m_dozens = 0; m_ovf = 0; m_prev = 0; m_pulse = 0;
        m_tens = 0; m_ones = 0;
    endtask

    task automatic model_step(input bit r, input bit c1, input bit add, input bit clr);
        bit evt;
        if (!r || clr) begin
            model_zero();
            return;
        end
        evt = add && !m_prev && (m_units == DS);
        m_tens = m_dozens / 10;
        m_ones = m_dozens % 10;
        if (evt) begin
            m_units = c1 ? 1 : 0;
            if (m_dozens < MAX) m_dozens++;
            else m_ovf = 1;
        end else if (c1) begin
            if (m_units < DS) m_units++;
            else m_ovf = 1;
        end
        m_pulse = evt;
        m_prev = add;
    endtask

    task automatic cyc(input bit r, input bit c1, input bit add, input bit clr);
        @(negedge clk);
        reset = r;
        bus.cont1 = c1;
        bus.add_cont12 = add;
        bus.clear = clr;
        model_step(r, c1, add, clr);
        q.push_back(snap());
    endtask

    task automatic book_dozen();
        while (m_units < DS) cyc(1, 1, 0, 0);
        cyc(1, 0, 1, 0);
        cyc(1, 0, 0, 0);
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".units"},  int'(bus.units),       e.units);
        chk({tag, ".dozens"}, int'(bus.dozens),      e.dozens);
        chk({tag, ".tens"},   int'(bus.bcd_tens),    e.tens);
        chk({tag, ".ones"},   int'(bus.bcd_ones),    e.ones);
        chk({tag, ".pulse"},  int'(bus.dozen_pulse), e.pulse);
        chk({tag, ".full"},   int'(bus.full),        e.full);
        chk({tag, ".ovf"},    int'(bus.overflow),    e.ovf);
        chk({tag, ".cont12"}, int'(bus.cont12),      e.cont12);
    endtask

    // Monitor: the DUT presents a fresh state every edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk_all("sb", e);
            end
        end
    end

    initial begin
        exp_t z;
        int wait_cnt;
        bus.cont1 = 0; bus.add_cont12 = 0; bus.clear = 0;
        model_zero();
        z = snap();
        repeat (3) @(negedge clk);
        chk_all("reset", z);

        // 12 single-cycle bottles, cont12 rises after the 12th
        for (int i = 0; i < 12; i++) begin
            cyc(1, 1, 0, 0);
            cyc(1, 0, 0, 0);
        end
        // Long add_cont12 high period books exactly one dozen
        repeat (5) cyc(1, 0, 1, 0);
        repeat (3) cyc(1, 0, 0, 0);
        // Dozen booked together with a bottle, then a 13th bottle overflows
        while (m_units < DS) cyc(1, 1, 0, 0);
        cyc(1, 1, 1, 0);
        cyc(1, 0, 0, 0);
        while (m_units < DS) cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        // Clear with cont1 high wins
        cyc(1, 1, 0, 1);
        cyc(1, 0, 0, 0);
        // Run to saturation, then one more dozen event
        while (m_dozens < MAX) book_dozen();
        repeat (2) cyc(1, 0, 0, 0);
        book_dozen();
        repeat (2) cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 1);
        // add_cont12 rising at units=5 is ignored
        repeat (5) cyc(1, 1, 0, 0);
        cyc(1, 0, 1, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 1);
        // Async reset mid-count at units=7, dozens=3
        repeat (3) book_dozen();
        repeat (7) cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        @(negedge clk);
        #2 reset = 0;
        model_zero();
        #1 chk_all("async_rst", snap());
        cyc(0, 0, 0, 0);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(1, $urandom_range(0, 99) < 65, $urandom_range(0, 5) == 0,
                $urandom_range(0, 299) == 0);
        end
        cyc(1, 0, 0, 0);

        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        chk("drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/contador_duzias_datapath.md
Name: contador_duzias_datapath

Overview:
- Datapath paired with the dozen-counting state machine in the automatic bottling line.
- Consumes that FSM's cont1 (one bottle detected) and add_cont12 (dozen complete) outputs.
- Keeps the bottle-in-dozen count and the total-dozens count, and returns the cont12 flag that steers the FSM.
- Also drives two-digit BCD dozens outputs for the seven-segment display stage and a full/overflow status.

Parameters:
- DOZEN_SIZE, 12, bottles per dozen; cont12 asserts when units == DOZEN_SIZE (legal 2..15).
- MAX_DOZENS, 99, dozens capacity; full asserts at this value (legal 1..99).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous clear of counters and flags, active-high.
- cont1  input  1  from FSM; count one bottle (level, sampled each cycle).
- add_cont12  input  1  from FSM; may stay high several cycles while the FSM sits in its dozen state.
- cont12  output  1  to FSM; units == DOZEN_SIZE.
- units  output  4  bottles in current dozen, 0..DOZEN_SIZE.
- dozens  output  7  completed dozens, 0..MAX_DOZENS.
- bcd_tens  output  4  tens digit of dozens.
- bcd_ones  output  4  ones digit of dozens.
- dozen_pulse  output  1  one-cycle pulse on each accepted dozen.
- full  output  1  dozens == MAX_DOZENS.
- overflow  output  1  sticky; a bottle or dozen was dropped.

Behaviour:
- Reset (reset=0, async): units=0, dozens=0, bcd_tens=0, bcd_ones=0, dozen_pulse=0, overflow=0, add_prev=0; cont12=0, full=0 follow from these.
- Priority each cycle: reset > clear > dozen event > cont1.
- clear=1 sets the same values as reset on the next edge and ignores all other inputs that cycle.
- cont12 is combinational from the units register: it rises in the cycle after the 12th cont1 is registered.
- Dozen event = add_cont12 & ~add_prev & (units == DOZEN_SIZE). add_prev is add_cont12 registered every cycle.
  - Only one dozen is counted per add_cont12 high period, however long it lasts.
  - add_cont12 rising while units != DOZEN_SIZE is ignored: no count, no overflow.
- On a dozen event:
  - units <= 0, or 1 if cont1=1 in the same cycle.
  - dozen_pulse=1 for one cycle.
  - If dozens < MAX_DOZENS then dozens+1; else dozens is held and overflow <= 1.
- cont1=1 with no dozen event:
  - units < DOZEN_SIZE: units+1.
  - units == DOZEN_SIZE: units held, overflow <= 1 (a bottle arrived before the dozen was booked).
- FSM handshake: after a dozen event, cont12 falls next cycle, which lets the FSM leave its dozen state.
- full is combinational (dozens == MAX_DOZENS). No wrap-around; dozens saturates.
- BCD digits are registered from the dozens register, giving 1 cycle of latency after dozens changes.
  - bcd_tens = dozens/10, bcd_ones = dozens%10.
  - Implement with a constant-compare or subtract chain; no generic divider.
- overflow clears only on reset or clear.
- Reset asserted mid-dozen discards partial units immediately, without waiting for a clock edge.

Test Plan:
- Reset then 12 single-cycle cont1 pulses -> units 1..12; cont12=1 the cycle after the 12th; dozens=0, overflow=0.
- From units=12, hold add_cont12 high 5 cycles -> exactly one dozen_pulse; dozens=1, units=0, cont12=0 next cycle; bcd_tens/bcd_ones = 0/1 one cycle after dozens changes.
- From units=12, raise add_cont12 together with cont1=1 -> units=1, dozens+1; then a 13th cont1 at units=12 with no add_cont12 -> units stays 12, overflow=1.
- Run 99 dozens (MAX_DOZENS=99) -> full=1, BCD=9/9; the 100th dozen event leaves dozens=99, units=0, overflow=1, dozen_pulse still 1.
- Assert reset low asynchronously mid-count (units=7, dozens=3) -> all outputs 0 before the next clk edge. Separately, clear=1 together with cont1=1 -> all counters 0 next edge.
- add_cont12 rising with units=5 -> no change to dozens/units, no dozen_pulse, overflow stays 0.
